umi_arbiter: RTL and testbench



---
 rtl/umi_arbiter_if.sv | 29 ++
 rtl/umi_arbiter.sv | 147 ++++++++++++++
 tb/tb_umi_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/umi_arbiter_if.sv
// Handshake bundle between N UMI requesters, the arbiter and the shared output channel.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface umi_arbiter_if #(
  parameter int unsigned N = 4
) ();

  logic [N-1:0] umi_in_valid;
  logic [N-1:0] umi_in_ready;
  logic [N-1:0] umi_grant;
  logic         umi_out_valid;
  logic         umi_out_ready;

  modport master (
    input  umi_in_valid,
    input  umi_out_ready,
    output umi_in_ready,
    output umi_grant,
    output umi_out_valid
  );

  modport slave (
    output umi_in_valid,
    output umi_out_ready,
    input  umi_in_ready,
    input  umi_grant,
    input  umi_out_valid
  );

endinterface

// File: rtl/umi_arbiter.sv
// N-way UMI arbiter: fixed-priority or round-robin, per-requester mask, grant lock while stalled.
// Optional starvation override enabled by defining UMI_ARB_STARVE_EN.
module umi_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          arb_mode,
  input  logic [N-1:0]  arb_mask,
`ifdef UMI_ARB_STARVE_EN
  input  logic          arb_starve_en,
`endif
  umi_arbiter_if.master umi
);

  if (N < 2 || N > 16 || CW < 1) begin : g_param_check
    $error("umi_arbiter: unsupported N or CW");
  end

  typedef enum logic [0:0] {StIdle, StLock} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] lock_q, lock_d;
  logic [N-1:0] ptr_q, ptr_d;

  logic [N-1:0] req;
  logic [N-1:0] hi_mask;
  logic [N-1:0] req_hi;
  logic [N-1:0] arb_gnt;
  logic [N-1:0] gnt;
  logic [N-1:0] xfer_vec;
  logic         xfer;

  // Isolates the lowest set bit (two's-complement trick).
  function automatic logic [N-1:0] lowest(input logic [N-1:0] x);
    return x & (~x + N'(1));
  endfunction

`ifdef UMI_ARB_STARVE_EN
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic [N-1:0]  starved;
`endif

  // Arbitration and grant selection.
  always_comb begin
    req     = umi.umi_in_valid & ~arb_mask;
    // Bits at or above the pointer position get first pick in round-robin.
    hi_mask = ~(ptr_q - N'(1));
    req_hi  = req & hi_mask;
    if (arb_mode) begin
      arb_gnt = (|req_hi) ? lowest(req_hi) : lowest(req);
    end else begin
      arb_gnt = lowest(req);
    end
`ifdef UMI_ARB_STARVE_EN
    for (int unsigned i = 0; i < N; i++) begin
      starved[i] = req[i] & (cnt_q[i] == {CW{1'b1}});
    end
    if (arb_starve_en && (|starved)) begin
      arb_gnt = lowest(starved);
    end
`endif
    if (state_q == StLock) begin
      gnt = lock_q & umi.umi_in_valid;
    end else begin
      gnt = arb_gnt;
    end
    if (!nreset) begin
      gnt = '0;
    end
    xfer_vec = gnt & {N{umi.umi_out_ready}};
    xfer     = |xfer_vec;
  end

  assign umi.umi_grant     = gnt;
  assign umi.umi_out_valid = |gnt;
  assign umi.umi_in_ready  = xfer_vec;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      ptr_d = {gnt[N-2:0], gnt[N-1]};
    end
    case (state_q)
      StIdle: begin
        if ((|gnt) && !umi.umi_out_ready) begin
          state_d = StLock;
          lock_d  = gnt;
        end
      end
      StLock: begin
        // Leave on transfer, or when the locked requester withdraws valid.
        if (xfer || !(|gnt)) begin
          state_d = StIdle;
          lock_d  = '0;
        end
      end
      default: begin
        state_d = StIdle;
        lock_d  = '0;
      end
    endcase
  end

`ifdef UMI_ARB_STARVE_EN
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!req[i] || xfer_vec[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != {CW{1'b1}}) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= StIdle;
      lock_q  <= '0;
      ptr_q   <= N'(1);
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef UMI_ARB_STARVE_EN
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N; i++) begin
      if (!nreset) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_umi_arbiter.sv
// Directed self-checking bench for umi_arbiter (N = 4); starvation test only with UMI_ARB_STARVE_EN.
module tb_umi_arbiter;

`ifdef UMI_ARB_STARVE_EN
  localparam int unsigned CwT = 2;
`else
  localparam int unsigned CwT = 8;
`endif

  localparam logic [3:0] RrSeq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  logic       clk;
  logic       nreset;
  logic       arb_mode;
  logic [3:0] arb_mask;
`ifdef UMI_ARB_STARVE_EN
  logic       arb_starve_en;
`endif

  int total;
  int bad;

  umi_arbiter_if #(.N(4)) umi ();

  umi_arbiter #(
    .N (4),
    .CW(CwT)
  ) dut (
    .clk          (clk),
    .nreset       (nreset),
    .arb_mode     (arb_mode),
    .arb_mask     (arb_mask),
`ifdef UMI_ARB_STARVE_EN
    .arb_starve_en(arb_starve_en),
`endif
    .umi          (umi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs at the falling edge and let combinational outputs settle.
  task automatic apply(input logic rst_n, input logic mode, input logic [3:0] mask,
                       input logic [3:0] valid, input logic ready);
    @(negedge clk);
    nreset             = rst_n;
    arb_mode           = mode;
    arb_mask           = mask;
    umi.umi_in_valid   = valid;
    umi.umi_out_ready  = ready;
    #1;
  endtask

  task automatic test_reset();
    apply(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1);
    total++;
    if (umi.umi_grant !== 4'b0000) begin
      bad++;
      $display("FAIL reset_grant got=%b want=0000", umi.umi_grant);
    end
    total++;
    if (umi.umi_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_out_valid got=%b want=0", umi.umi_out_valid);
    end
    total++;
    if (umi.umi_in_ready !== 4'b0000) begin
      bad++;
      $display("FAIL reset_in_ready got=%b want=0000", umi.umi_in_ready);
    end
  endtask

  task automatic test_fixed();
    for (int c = 0; c < 4; c++) begin
      apply(1'b1, 1'b0, 4'b0000, 4'b1010, 1'b1);
      total++;
      if (umi.umi_grant !== 4'b0010 || umi.umi_in_ready !== 4'b0010) begin
        bad++;
        $display("FAIL fixed_grant cyc=%0d got=%b/%b want=0010/0010", c, umi.umi_grant,
                 umi.umi_in_ready);
      end
    end
  endtask

  task automatic test_round_robin();
    apply(1'b0, 1'b1, 4'b0000, 4'b1111, 1'b1);
    for (int c = 0; c < 5; c++) begin
      apply(1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1);
      total++;
      if (umi.umi_grant !== RrSeq[c] || umi.umi_out_valid !== 1'b1) begin
        bad++;
        $display("FAIL rr_back_to_back cyc=%0d got=%b/%b want=%b/1", c, umi.umi_grant,
                 umi.umi_out_valid, RrSeq[c]);
      end
    end
  endtask

  task automatic test_lock();
    apply(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
    apply(1'b1, 1'b1, 4'b0000, 4'b0010, 1'b0);
    total++;
    if (umi.umi_grant !== 4'b0010 || umi.umi_in_ready !== 4'b0000) begin
      bad++;
      $display("FAIL lock_first got=%b/%b want=0010/0000", umi.umi_grant, umi.umi_in_ready);
    end
    // Index 0 now requests, mode flips to fixed and index 1 gets masked: the lock must hold.
    for (int c = 0; c < 3; c++) begin
      apply(1'b1, (c == 0), (c == 0) ? 4'b0000 : 4'b0010, 4'b0011, 1'b0);
      total++;
      if (umi.umi_grant !== 4'b0010 || umi.umi_in_ready !== 4'b0000) begin
        bad++;
        $display("FAIL lock_hold cyc=%0d got=%b/%b want=0010/0000", c, umi.umi_grant,
                 umi.umi_in_ready);
      end
    end
    apply(1'b1, 1'b0, 4'b0010, 4'b0011, 1'b1);
    total++;
    if (umi.umi_grant !== 4'b0010 || umi.umi_in_ready !== 4'b0010) begin
      bad++;
      $display("FAIL lock_release got=%b/%b want=0010/0010", umi.umi_grant, umi.umi_in_ready);
    end
    apply(1'b1, 1'b0, 4'b0010, 4'b0011, 1'b1);
    total++;
    if (umi.umi_grant !== 4'b0001) begin
      bad++;
      $display("FAIL lock_after got=%b want=0001", umi.umi_grant);
    end
  endtask

  task automatic test_lock_drop();
    apply(1'b1, 1'b0, 4'b0000, 4'b0100, 1'b0);
    total++;
    if (umi.umi_grant !== 4'b0100) begin
      bad++;
      $display("FAIL drop_grant got=%b want=0100", umi.umi_grant);
    end
    apply(1'b1, 1'b0, 4'b0000, 4'b0001, 1'b0);
    total++;
    if (umi.umi_grant !== 4'b0000 || umi.umi_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drop_violation got=%b/%b want=0000/0", umi.umi_grant, umi.umi_out_valid);
    end
    apply(1'b1, 1'b0, 4'b0000, 4'b0001, 1'b1);
    total++;
    if (umi.umi_grant !== 4'b0001) begin
      bad++;
      $display("FAIL drop_recover got=%b want=0001", umi.umi_grant);
    end
  endtask

  task automatic test_mask();
    apply(1'b1, 1'b0, 4'b0001, 4'b0011, 1'b1);
    total++;
    if (umi.umi_grant !== 4'b0010) begin
      bad++;
      $display("FAIL mask_grant got=%b want=0010", umi.umi_grant);
    end
    apply(1'b1, 1'b0, 4'b0001, 4'b0001, 1'b1);
    total++;
    if (umi.umi_grant !== 4'b0000 || umi.umi_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mask_all got=%b/%b want=0000/0", umi.umi_grant, umi.umi_out_valid);
    end
  endtask

  task automatic test_reset_mid_lock();
    // Pointer sits at index 2 after the mask test's transfer from index 1.
    apply(1'b1, 1'b1, 4'b0000, 4'b1111, 1'b0);
    total++;
    if (umi.umi_grant !== 4'b0100) begin
      bad++;
      $display("FAIL midlock_grant got=%b want=0100", umi.umi_grant);
    end
    apply(1'b0, 1'b1, 4'b0000, 4'b1111, 1'b1);
    total++;
    if (umi.umi_grant !== 4'b0000 || umi.umi_in_ready !== 4'b0000 ||
        umi.umi_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midlock_in_reset got=%b/%b/%b want=0000/0000/0", umi.umi_grant,
               umi.umi_in_ready, umi.umi_out_valid);
    end
    apply(1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1);
    total++;
    if (umi.umi_grant !== 4'b0001) begin
      bad++;
      $display("FAIL midlock_restart got=%b want=0001", umi.umi_grant);
    end
    apply(1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1);
    total++;
    if (umi.umi_grant !== 4'b0010) begin
      bad++;
      $display("FAIL midlock_next got=%b want=0010", umi.umi_grant);
    end
  endtask

`ifdef UMI_ARB_STARVE_EN
  task automatic test_starve();
    arb_starve_en = 1'b1;
    apply(1'b0, 1'b0, 4'b0000, 4'b1001, 1'b1);
    for (int c = 0; c < 5; c++) begin
      apply(1'b1, 1'b0, 4'b0000, 4'b1001, 1'b1);
      total++;
      if (umi.umi_grant !== ((c == 3) ? 4'b1000 : 4'b0001)) begin
        bad++;
        $display("FAIL starve cyc=%0d got=%b want=%b", c, umi.umi_grant,
                 (c == 3) ? 4'b1000 : 4'b0001);
      end
    end
  endtask
`endif

  initial begin
    total             = 0;
    bad               = 0;
    nreset            = 1'b0;
    arb_mode          = 1'b0;
    arb_mask          = 4'b0000;
    umi.umi_in_valid  = 4'b0000;
    umi.umi_out_ready = 1'b0;
`ifdef UMI_ARB_STARVE_EN
    arb_starve_en     = 1'b0;
`endif
    test_reset();
    test_fixed();
    test_round_robin();
    test_lock();
    test_lock_drop();
    test_mask();
    test_reset_mid_lock();
`ifdef UMI_ARB_STARVE_EN
    test_starve();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
